// File: rtl/fifo_pkg.sv
// Shared defaults for the asynchronous FIFO read path.
// Also holds the helper that sizes the prefetch level counter.
package fifo_pkg;

   localparam int DEF_DATASIZE  = 8;
   localparam int DEF_ADDRSIZE  = 4;
   localparam int DEF_BUF_DEPTH = 3;

   // The counter must hold the value BUF_DEPTH itself, not just BUF_DEPTH-1.
   function automatic int level_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/rd_prefetch_buf.sv
// Prefetch storage ring: holds words captured from the FIFO memory until the consumer takes them.
// Both indices wrap explicitly, so BUF_DEPTH does not need to be a power of two.
module rd_prefetch_buf
   import fifo_pkg::*;
#(
   parameter int DATASIZE  = DEF_DATASIZE,
   parameter int BUF_DEPTH = DEF_BUF_DEPTH,
   parameter int LVLW      = level_width(BUF_DEPTH)
) (
   input  logic                rclk,
   input  logic                rrst_n,
   input  logic                wr_en,
   input  logic [DATASIZE-1:0] wr_data,
   input  logic                rd_en,
   output logic [DATASIZE-1:0] head,
   output logic [LVLW-1:0]     count
);

   localparam int IDXW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BUF_DEPTH - 1);

   logic [DATASIZE-1:0] storage [BUF_DEPTH];
   logic [IDXW-1:0]     wr_idx;
   logic [IDXW-1:0]     rd_idx;

   function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] idx);
      return (idx == LAST_IDX) ? '0 : idx + 1'b1;
   endfunction

   // Data storage carries no reset; an entry is only read once count says it was written.
   always_ff @(posedge rclk) begin
      if (wr_en) begin
         storage[wr_idx] <= wr_data;
      end
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         wr_idx <= '0;
         rd_idx <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_idx <= next_idx(wr_idx);
         end
         if (rd_en) begin
            rd_idx <= next_idx(rd_idx);
         end
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head = storage[rd_idx];

endmodule

// File: rtl/fifo_rd_prefetch.sv
// Read-side output stage: turns rinc/rempty pops plus the 1-cycle registered memory read
// into a first-word-fall-through valid/ready stream, with no m_ready->rinc combinational path.
module fifo_rd_prefetch
   import fifo_pkg::*;
#(
   parameter int DATASIZE  = DEF_DATASIZE,
   parameter int BUF_DEPTH = DEF_BUF_DEPTH,
   parameter int LVLW      = level_width(BUF_DEPTH)
) (
   input  logic                rclk,
   input  logic                rrst_n,
   input  logic                rempty,
   input  logic [DATASIZE-1:0] rdata,
   output logic                rinc,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [DATASIZE-1:0] m_data,
   output logic [LVLW-1:0]     rlevel
);

   localparam logic [LVLW:0] CREDIT_MAX = (LVLW + 1)'(BUF_DEPTH);

   logic            inflight;
   logic            deq;
   logic [LVLW-1:0] count;
   logic [LVLW:0]   credit;

   // A word popped last cycle already owns a slot, so it is counted before the next pop is allowed.
   assign credit = {1'b0, count} + {{LVLW{1'b0}}, inflight};
   assign rinc   = ~rempty & (credit < CREDIT_MAX);

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         inflight <= 1'b0;
      end else begin
         inflight <= rinc;
      end
   end

   assign m_valid = (count != '0);
   assign deq     = m_valid & m_ready;
   assign rlevel  = count;

   rd_prefetch_buf #(
      .DATASIZE  (DATASIZE),
      .BUF_DEPTH (BUF_DEPTH),
      .LVLW      (LVLW)
   ) u_buf (
      .rclk    (rclk),
      .rrst_n  (rrst_n),
      .wr_en   (inflight),
      .wr_data (rdata),
      .rd_en   (deq),
      .head    (m_data),
      .count   (count)
   );

   a_no_overflow: assert property (@(posedge rclk) disable iff (!rrst_n)
      {1'b0, count} <= CREDIT_MAX);

   a_credit_bound: assert property (@(posedge rclk) disable iff (!rrst_n)
      credit <= CREDIT_MAX);

   a_no_pop_when_empty: assert property (@(posedge rclk) disable iff (!rrst_n)
      rempty |-> !rinc);

   a_hold_under_backpressure: assert property (@(posedge rclk) disable iff (!rrst_n)
      (m_valid && !m_ready) |=> (m_valid && $stable(m_data)));

endmodule

// File: tb/tb_fifo_rd_prefetch.sv
// Bench for fifo_rd_prefetch: a queue-based upstream FIFO and prefetch-buffer model,
// checked every cycle, plus end-to-end word-order checks on directed and random traffic.
module tb_fifo_rd_prefetch;

   localparam int DEPTH = 3;

   logic       rclk = 1'b0;
   logic       rrst_n;
   logic       rempty;
   logic [7:0] rdata;
   logic       rinc;
   logic       m_valid;
   logic       m_ready;
   logic [7:0] m_data;
   logic [1:0] rlevel;

   fifo_rd_prefetch dut (
      .rclk    (rclk),
      .rrst_n  (rrst_n),
      .rempty  (rempty),
      .rdata   (rdata),
      .rinc    (rinc),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .rlevel  (rlevel)
   );

   always #5 rclk = ~rclk;

   int checks = 0;
   int errors = 0;

   logic [7:0] fifo_q [$];
   logic [7:0] mbuf [$];
   logic [7:0] exp_q [$];
   logic [7:0] got_q [$];
   int         deliver_cyc [$];
   bit         m_infl = 1'b0;
   int         cyc = 0;
   int         rinc_pulses = 0;
   int         max_level = 0;
   bit         pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic pushWord(input logic [7:0] v);
      fifo_q.push_back(v);
      exp_q.push_back(v);
   endtask

   // One rclk cycle: advance the model at the edge, drive upstream/m_ready, then compare.
   task automatic applyStimulus(input bit rdy);
      bit         exp_rinc;
      logic [7:0] nxt;
      @(posedge rclk);
      cyc++;
      nxt = 8'($urandom);
      if (rrst_n) begin
         exp_rinc = !rempty && ((mbuf.size() + int'(m_infl)) < DEPTH);
         if (exp_rinc) nxt = fifo_q.pop_front();
         if (mbuf.size() != 0 && m_ready) void'(mbuf.pop_front());
         if (m_infl) mbuf.push_back(rdata);
         m_infl = exp_rinc;
      end else begin
         mbuf.delete();
         m_infl = 1'b0;
      end
      #1;
      rdata   = nxt;
      rempty  = !rrst_n || (fifo_q.size() == 0);
      m_ready = rdy;
      #1;
      checkOutput("rinc", 32'(rinc),
                  32'(rrst_n && !rempty && ((mbuf.size() + int'(m_infl)) < DEPTH)));
      checkOutput("m_valid", 32'(m_valid), 32'(mbuf.size() != 0));
      checkOutput("rlevel", 32'(rlevel), mbuf.size());
      if (mbuf.size() != 0) checkOutput("m_data", 32'(m_data), 32'(mbuf[0]));
      if (rinc) rinc_pulses++;
      if (int'(rlevel) > max_level) max_level = int'(rlevel);
      if (m_valid && m_ready) begin
         got_q.push_back(m_data);
         deliver_cyc.push_back(cyc);
      end
   endtask

   task automatic runUntil(input int n, input int budget, input bit rdy);
      int c = 0;
      while (got_q.size() < n && c < budget) begin
         applyStimulus(rdy);
         c++;
      end
   endtask

   task automatic checkWords(input string tag);
      checkOutput({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checkOutput(tag, 32'(got_q[i]), 32'(exp_q[i]));
      end
      got_q.delete();
      exp_q.delete();
      deliver_cyc.delete();
   endtask

   initial begin
      int n;
      int bubbles;
      int c;
      rrst_n  = 1'b0;
      rempty  = 1'b1;
      rdata   = 8'h00;
      m_ready = 1'b0;
      #1;
      checkOutput("reset_m_valid", 32'(m_valid), 0);
      checkOutput("reset_rlevel", 32'(rlevel), 0);
      checkOutput("reset_rinc", 32'(rinc), 0);
      applyStimulus(1'b0);
      applyStimulus(1'b0);
      rrst_n = 1'b1;
      applyStimulus(1'b1);
      applyStimulus(1'b1);

      $display("[TB] single word");
      rinc_pulses = 0;
      pushWord(8'hA5);
      n = 0;
      do begin
         applyStimulus(1'b1);
         n++;
      end while (!m_valid && n < 10);
      checkOutput("single_latency", n, 3);
      checkOutput("single_data", 32'(m_data), 32'h0A5);
      applyStimulus(1'b1);
      checkOutput("single_after_valid", 32'(m_valid), 0);
      checkOutput("single_rinc_pulses", rinc_pulses, 1);
      checkWords("single_word");

      $display("[TB] streaming");
      for (int i = 0; i < 16; i++) pushWord(8'(i));
      runUntil(16, 40, 1'b1);
      bubbles = 0;
      for (int i = 1; i < deliver_cyc.size(); i++) begin
         if (deliver_cyc[i] - deliver_cyc[i-1] != 1) bubbles++;
      end
      checkOutput("stream_bubbles", bubbles, 0);
      checkWords("stream_word");

      $display("[TB] backpressure");
      applyStimulus(1'b0);
      rinc_pulses = 0;
      for (int i = 0; i < 8; i++) pushWord(8'(i));
      for (int i = 0; i < 8; i++) applyStimulus(1'b0);
      checkOutput("bp_rinc_pulses", rinc_pulses, 3);
      checkOutput("bp_rlevel", 32'(rlevel), 3);
      checkOutput("bp_m_data", 32'(m_data), 32'h00);
      checkOutput("bp_m_valid", 32'(m_valid), 1);
      runUntil(8, 40, 1'b1);
      checkWords("bp_word");

      $display("[TB] stall pattern with wrap");
      max_level = 0;
      for (int i = 0; i < 20; i++) pushWord(8'($urandom));
      c = 0;
      while (got_q.size() < 20 && c < 200) begin
         applyStimulus(pat[c % 6]);
         c++;
      end
      checkOutput("stall_max_level_ok", 32'(max_level <= DEPTH), 1);
      checkWords("stall_word");

      $display("[TB] empty during prefetch");
      applyStimulus(1'b0);
      pushWord(8'h11);
      pushWord(8'h22);
      for (int i = 0; i < 6; i++) applyStimulus(1'b0);
      checkOutput("empty_rlevel2", 32'(rlevel), 2);
      checkOutput("empty_rinc_idle", 32'(rinc), 0);
      pushWord(8'h33);
      for (int i = 0; i < 6; i++) applyStimulus(1'b0);
      checkOutput("empty_rlevel3", 32'(rlevel), 3);
      checkOutput("empty_rinc_full", 32'(rinc), 0);
      checkOutput("empty_head", 32'(m_data), 32'h11);
      runUntil(3, 20, 1'b1);
      checkWords("empty_word");

      $display("[TB] reset mid-stream");
      applyStimulus(1'b0);
      pushWord(8'h5A);
      pushWord(8'hC3);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0);
      checkOutput("rst_pre_rlevel", 32'(rlevel), 2);
      rrst_n = 1'b0;
      rempty = 1'b1;
      fifo_q.delete();
      exp_q.delete();
      mbuf.delete();
      m_infl = 1'b0;
      #1;
      checkOutput("rst_m_valid", 32'(m_valid), 0);
      checkOutput("rst_rlevel", 32'(rlevel), 0);
      checkOutput("rst_rinc", 32'(rinc), 0);
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      rrst_n = 1'b1;
      for (int i = 0; i < 4; i++) applyStimulus(1'b1);
      checkOutput("rst_post_m_valid", 32'(m_valid), 0);
      checkOutput("rst_post_rlevel", 32'(rlevel), 0);
      checkOutput("rst_post_rinc", 32'(rinc), 0);
      checkWords("rst_word");

      $display("[TB] random traffic");
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 2) == 0) pushWord(8'($urandom));
         applyStimulus(1'($urandom_range(0, 1)));
      end
      n = exp_q.size();
      runUntil(n, 100, 1'b1);
      checkWords("random_word");

      $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
